// File: rtl/reg_bus_arbiter.sv
// Two-host arbiter for the shared board register bus (port 0 = FireWire, port 1 = Ethernet).
// Serializes quadlet reads/writes, round-robins ties and supports a timed bus lock.
module reg_bus_arbiter #(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned LOCK_TMO = 4915
) (
  input  logic        i_sysclk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_wr0,
  input  logic        i_wr1,
  input  logic        i_lock0,
  input  logic        i_lock1,
  input  logic [15:0] i_addr0,
  input  logic [15:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic [15:0] o_reg_raddr,
  output logic [15:0] o_reg_waddr,
  output logic [31:0] o_reg_wdata,
  output logic        o_reg_wen,
  input  logic [31:0] i_reg_rdata,
  output logic        o_owner,
  output logic        o_busy,
  output logic        o_lock_err
);

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StAck
  } state_e;

  localparam logic [2:0] RdLast = 3'(RD_LAT - 1);
  localparam bit TmoEn = (LOCK_TMO != 0);
  // Index of the last tolerated idle cycle, clamped to the 16-bit counter range.
  localparam int unsigned TmoLastI = (LOCK_TMO == 0) ? 0 :
                                     ((LOCK_TMO > 65536) ? 65535 : LOCK_TMO - 1);
  localparam logic [15:0] TmoLast = 16'(TmoLastI);

  state_e      r_state;
  state_e      w_state_next;

  logic        r_owner;
  logic        r_last_grant;
  logic        r_lock;
  logic [2:0]  r_rd_cnt;
  logic [15:0] r_tmo_cnt;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic [15:0] r_reg_raddr;
  logic [15:0] r_reg_waddr;
  logic [31:0] r_reg_wdata;

  logic        w_idle;
  logic        w_owner_req;
  logic        w_owner_lock;
  logic        w_tmo_exp;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant;
  logic        w_grant_port;
  logic        w_grant_wr;
  logic [15:0] w_grant_addr;
  logic [31:0] w_grant_wdata;
  logic        w_rd_done;
  logic        w_tmo_count;

  assign w_idle       = (r_state == StIdle);
  assign w_owner_req  = r_owner ? i_req1 : i_req0;
  assign w_owner_lock = r_owner ? i_lock1 : i_lock0;

  // Expiry is suppressed when the lock owner requests in the same cycle: the owner wins.
  assign w_tmo_exp = w_idle && r_lock && TmoEn && !w_owner_req && (r_tmo_cnt >= TmoLast);

  assign w_elig0 = i_req0 && (!r_lock || !r_owner || w_tmo_exp);
  assign w_elig1 = i_req1 && (!r_lock ||  r_owner || w_tmo_exp);

  assign w_grant       = w_idle && (w_elig0 || w_elig1);
  assign w_grant_port  = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;
  assign w_grant_wr    = w_grant_port ? i_wr1    : i_wr0;
  assign w_grant_addr  = w_grant_port ? i_addr1  : i_addr0;
  assign w_grant_wdata = w_grant_port ? i_wdata1 : i_wdata0;

  assign w_rd_done   = (r_state == StRd) && (r_rd_cnt == RdLast);
  assign w_tmo_count = w_idle && r_lock && !w_owner_req && (r_tmo_cnt != 16'hFFFF);

  // State register
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_next = w_grant_wr ? StWr : StRd;
        end
      end
      StWr:    w_state_next = StAck;
      StRd: begin
        if (w_rd_done) begin
          w_state_next = StAck;
        end
      end
      StAck:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    o_reg_wen  = 1'b0;
    o_ack0     = 1'b0;
    o_ack1     = 1'b0;
    o_busy     = !w_idle || r_lock;
    o_lock_err = w_tmo_exp;
    case (r_state)
      StWr:  o_reg_wen = 1'b1;
      StAck: begin
        o_ack0 = !r_owner;
        o_ack1 =  r_owner;
      end
      default: ;
    endcase
  end

  // Datapath, grant bookkeeping and lock tracking
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_lock       <= 1'b0;
      r_rd_cnt     <= 3'd0;
      r_tmo_cnt    <= 16'd0;
      r_rdata0     <= 32'd0;
      r_rdata1     <= 32'd0;
      r_reg_raddr  <= 16'd0;
      r_reg_waddr  <= 16'd0;
      r_reg_wdata  <= 32'd0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_grant_port;
        r_tmo_cnt <= 16'd0;
        r_rd_cnt  <= 3'd0;
        if (w_grant_wr) begin
          r_reg_waddr <= w_grant_addr;
          r_reg_wdata <= w_grant_wdata;
        end else begin
          r_reg_raddr <= w_grant_addr;
        end
      end else if (w_tmo_count) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end

      if (w_tmo_exp) begin
        r_lock <= 1'b0;
      end

      if (r_state == StRd) begin
        r_rd_cnt <= r_rd_cnt + 3'd1;
        if (w_rd_done) begin
          if (r_owner) begin
            r_rdata1 <= i_reg_rdata;
          end else begin
            r_rdata0 <= i_reg_rdata;
          end
        end
      end

      if (r_state == StAck) begin
        r_lock       <= w_owner_lock;
        r_last_grant <= r_owner;
      end
    end
  end

  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_reg_raddr = r_reg_raddr;
  assign o_reg_waddr = r_reg_waddr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_owner     = r_owner;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: per-port scoreboards of expected acks and write strobes,
// plus explicit latency, ordering, lock and reset checks.
module tb_reg_bus_arbiter;

  localparam int unsigned RdLat   = 2;
  localparam int unsigned LockTmo = 8;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wen_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        wr    [2];
  logic        lk    [2];
  logic [15:0] addr  [2];
  logic [31:0] wdata [2];

  logic        ack0, ack1, reg_wen, owner, busy, lock_err;
  logic [31:0] rdata0, rdata1, reg_wdata;
  logic [31:0] reg_rdata = 32'd0;
  logic [15:0] reg_raddr, reg_waddr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lerr_cnt = 0;
  int lerr_cyc = -1;
  int l0, l1, t;

  ack_exp_t    aq0 [$];
  ack_exp_t    aq1 [$];
  wen_exp_t    wq0 [$];
  wen_exp_t    wq1 [$];
  int          ack_log [$];
  logic [31:0] m_rdata [2];

  reg_bus_arbiter #(
    .RD_LAT  (RdLat),
    .LOCK_TMO(LockTmo)
  ) dut (
    .i_sysclk   (clk),
    .i_reset    (rst),
    .i_req0     (req[0]),
    .i_req1     (req[1]),
    .i_wr0      (wr[0]),
    .i_wr1      (wr[1]),
    .i_lock0    (lk[0]),
    .i_lock1    (lk[1]),
    .i_addr0    (addr[0]),
    .i_addr1    (addr[1]),
    .i_wdata0   (wdata[0]),
    .i_wdata1   (wdata[1]),
    .o_ack0     (ack0),
    .o_ack1     (ack1),
    .o_rdata0   (rdata0),
    .o_rdata1   (rdata1),
    .o_reg_raddr(reg_raddr),
    .o_reg_waddr(reg_waddr),
    .o_reg_wdata(reg_wdata),
    .o_reg_wen  (reg_wen),
    .i_reg_rdata(reg_rdata),
    .o_owner    (owner),
    .o_busy     (busy),
    .o_lock_err (lock_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [15:0] a);
    return (a == 16'h0004) ? 32'h514C4131 : {~a, a};
  endfunction

  // Register file model: data for the address presented on the previous edge.
  always @(posedge clk) reg_rdata <= mem_f(reg_raddr);

  function automatic void check(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack0"}, {31'd0, ack0}, 32'd0);
    check({tag, "_ack1"}, {31'd0, ack1}, 32'd0);
    check({tag, "_rdata0"}, rdata0, 32'd0);
    check({tag, "_rdata1"}, rdata1, 32'd0);
    check({tag, "_raddr"}, {16'd0, reg_raddr}, 32'd0);
    check({tag, "_waddr"}, {16'd0, reg_waddr}, 32'd0);
    check({tag, "_wdata"}, reg_wdata, 32'd0);
    check({tag, "_wen"}, {31'd0, reg_wen}, 32'd0);
    check({tag, "_owner"}, {31'd0, owner}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_lock_err"}, {31'd0, lock_err}, 32'd0);
  endtask

  // One host transaction; must be entered just after a rising edge.
  task automatic txn(input int p, input bit w, input logic [15:0] a, input logic [31:0] d,
                     input bit l, output int lat);
    ack_exp_t e;
    wen_exp_t we;
    bit       got;
    int       t0;
    e.wr    = w;
    e.rdata = mem_f(a);
    we.addr = a;
    we.data = d;
    if (p == 0) aq0.push_back(e);
    else        aq1.push_back(e);
    if (w) begin
      if (p == 0) wq0.push_back(we);
      else        wq1.push_back(we);
    end
    wr[p] = w; addr[p] = a; wdata[p] = d; lk[p] = l; req[p] = 1'b1;
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    lat = cyc - t0;
    check($sformatf("p%0d_ack_seen", p), {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  // Monitor: scoreboard pops on acks and write strobes, rdata hold checks.
  initial begin : mon
    ack_exp_t e;
    wen_exp_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
      end else begin
        if (ack0) begin
          ack_log.push_back(0);
          if (aq0.size() == 0) check("ack0_unexpected", {31'd0, ack0}, 32'd0);
          else begin
            e = aq0.pop_front();
            if (!e.wr) m_rdata[0] = e.rdata;
          end
        end
        if (ack1) begin
          ack_log.push_back(1);
          if (aq1.size() == 0) check("ack1_unexpected", {31'd0, ack1}, 32'd0);
          else begin
            e = aq1.pop_front();
            if (!e.wr) m_rdata[1] = e.rdata;
          end
        end
        check("rdata0", rdata0, m_rdata[0]);
        check("rdata1", rdata1, m_rdata[1]);
        if (reg_wen) begin
          if ((owner == 1'b0 && wq0.size() == 0) || (owner == 1'b1 && wq1.size() == 0)) begin
            check("wen_unexpected", {31'd0, reg_wen}, 32'd0);
          end else begin
            w = (owner == 1'b0) ? wq0.pop_front() : wq1.pop_front();
            check("reg_waddr", {16'd0, reg_waddr}, {16'd0, w.addr});
            check("reg_wdata", reg_wdata, w.data);
          end
        end
        if (lock_err) begin
          lerr_cnt++;
          lerr_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; wr[p] = 1'b0; lk[p] = 1'b0; addr[p] = 16'd0; wdata[p] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write from port 0
    txn(0, 1'b1, 16'h0003, 32'h00001680, 1'b0, l0);
    check("wr_latency", l0, 32'd2);
    check("wr_owner", {31'd0, owner}, 32'd0);

    // Single read from port 1
    txn(1, 1'b0, 16'h0004, 32'd0, 1'b0, l1);
    check("rd_latency", l1, 32'd3);
    check("rd_rdata1", rdata1, 32'h514C4131);
    check("rd_owner", {31'd0, owner}, 32'd1);
    check("rd_raddr_hold", {16'd0, reg_raddr}, 32'h0004);
    check("rd_waddr_hold", {16'd0, reg_waddr}, 32'h0003);

    // Round robin from reset: port 0 first, then alternating
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    ack_log.delete();
    for (int r = 0; r < 2; r++) begin
      fork
        txn(0, 1'b1, 16'h0010 + 16'(r), 32'hA5A50000 + r, 1'b0, l0);
        txn(1, 1'b0, 16'h0020 + 16'(r), 32'd0, 1'b0, l1);
      join
      check($sformatf("tie%0d_lat0", r), l0, 32'd2);
      check($sformatf("tie%0d_lat1", r), l1, 32'd6);
    end
    check("tie_count", ack_log.size(), 32'd4);
    for (int i = 0; i < ack_log.size(); i++) begin
      check($sformatf("tie_order%0d", i), ack_log[i], i % 2);
    end

    // Port 1 holds the lock over three reads while port 0 waits
    ack_log.delete();
    fork
      begin
        txn(1, 1'b0, 16'h0030, 32'd0, 1'b1, l1);
        txn(1, 1'b0, 16'h0031, 32'd0, 1'b1, l1);
        txn(1, 1'b0, 16'h0032, 32'd0, 1'b0, l1);
      end
      begin
        @(posedge clk);
        #1;
        txn(0, 1'b0, 16'h0040, 32'd0, 1'b0, l0);
      end
    join
    check("lock_p0_latency", l0, 32'd14);
    check("lock_count", ack_log.size(), 32'd4);
    for (int i = 0; i < ack_log.size(); i++) begin
      check($sformatf("lock_order%0d", i), ack_log[i], (i < 3) ? 1 : 0);
    end

    // Lock timeout: port 0 locks and goes idle, port 1 waits
    lerr_cnt = 0;
    txn(0, 1'b1, 16'h0050, 32'hDEAD0001, 1'b1, l0);
    t = cyc;
    check("tmo_busy_locked", {31'd0, busy}, 32'd1);
    txn(1, 1'b0, 16'h0004, 32'd0, 1'b0, l1);
    check("tmo_lerr_count", lerr_cnt, 32'd1);
    check("tmo_lerr_cycle", lerr_cyc, t + 7);
    check("tmo_p1_latency", l1, 32'd10);

    // Owner request on the expiry cycle beats the timeout
    lerr_cnt = 0;
    ack_log.delete();
    txn(0, 1'b1, 16'h0060, 32'h0000BEEF, 1'b1, l0);
    repeat (7) @(posedge clk);
    #1;
    fork
      txn(0, 1'b0, 16'h0061, 32'd0, 1'b0, l0);
      txn(1, 1'b1, 16'h0062, 32'h00C0FFEE, 1'b0, l1);
    join
    check("sim_lerr_count", lerr_cnt, 32'd0);
    check("sim_p0_latency", l0, 32'd3);
    check("sim_p1_latency", l1, 32'd6);
    check("sim_count", ack_log.size(), 32'd3);

    // Reset in the middle of a read
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0004; lk[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_rd");
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_rd_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a write
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0070; wdata[0] = 32'h12345678; lk[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_wr");
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_wr_idle_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_no_wen_waddr", {16'd0, reg_waddr}, 32'd0);

    check("aq0_drained", aq0.size(), 32'd0);
    check("aq1_drained", aq1.size(), 32'd0);
    check("wq0_drained", wq0.size(), 32'd0);
    check("wq1_drained", wq1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
